// File: rtl/window_addr_gen.sv
// Sliding-window tap address generator: walks every WIN x WIN window of a row-major
// image, origins stepping by STRIDE, and streams tap addresses over valid/ready.
module window_addr_gen #(
   parameter int IMG_W  = 50,
   parameter int IMG_H  = 50,
   parameter int WIN    = 3,
   parameter int STRIDE = 1,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic              win_first,
   output logic              win_last,
   output logic              busy,
   output logic              frame_done
);

   localparam int TW = $clog2(WIN + 1);
   localparam int CW = $clog2(IMG_W + 1);
   localparam int RW = $clog2(IMG_H + 1);

   localparam logic [TW-1:0]     TX_LAST  = TW'(WIN - 1);
   localparam logic [CW-1:0]     LAST_C   = CW'(((IMG_W - WIN) / STRIDE) * STRIDE);
   localparam logic [RW-1:0]     LAST_R   = RW'(((IMG_H - WIN) / STRIDE) * STRIDE);
   localparam logic [CW-1:0]     STEP_C   = CW'(STRIDE);
   localparam logic [RW-1:0]     STEP_R   = RW'(STRIDE);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - (WIN - 1));
   localparam logic [ADDR_W-1:0] COL_JUMP = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] ROW_JUMP = ADDR_W'(STRIDE * IMG_W);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state_r;
   logic [TW-1:0]     tx_r, ty_r, tx_n_s, ty_n_s;
   logic [CW-1:0]     c_r, c_n_s;
   logic [RW-1:0]     r_r, r_n_s;
   logic [ADDR_W-1:0] addr_r, addr_n_s;
   logic [ADDR_W-1:0] org_r, org_n_s;
   logic [ADDR_W-1:0] row_base_r, row_base_n_s;
   logic              valid_r, first_r, last_r, busy_r, done_r;
   logic              final_s, first_n_s, last_n_s;

   // Next-tap datapath: +1 per tap, row step per window row, origin jumps per window.
   always_comb begin
      tx_n_s       = tx_r;
      ty_n_s       = ty_r;
      c_n_s        = c_r;
      r_n_s        = r_r;
      addr_n_s     = addr_r;
      org_n_s      = org_r;
      row_base_n_s = row_base_r;
      final_s      = 1'b0;
      if (tx_r != TX_LAST) begin
         tx_n_s   = tx_r + TW'(1);
         addr_n_s = addr_r + ADDR_W'(1);
      end else if (ty_r != TX_LAST) begin
         tx_n_s   = '0;
         ty_n_s   = ty_r + TW'(1);
         addr_n_s = addr_r + ROW_STEP;
      end else begin
         tx_n_s = '0;
         ty_n_s = '0;
         if (c_r != LAST_C) begin
            c_n_s    = c_r + STEP_C;
            org_n_s  = org_r + COL_JUMP;
            addr_n_s = org_r + COL_JUMP;
         end else if (r_r != LAST_R) begin
            c_n_s        = '0;
            r_n_s        = r_r + STEP_R;
            row_base_n_s = row_base_r + ROW_JUMP;
            org_n_s      = row_base_r + ROW_JUMP;
            addr_n_s     = row_base_r + ROW_JUMP;
         end else begin
            final_s = 1'b1;
         end
      end
      first_n_s = (tx_n_s == '0) && (ty_n_s == '0);
      last_n_s  = (tx_n_s == TX_LAST) && (ty_n_s == TX_LAST);
   end

   // Control FSM with registered stream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         tx_r       <= '0;
         ty_r       <= '0;
         c_r        <= '0;
         r_r        <= '0;
         addr_r     <= '0;
         org_r      <= '0;
         row_base_r <= '0;
         valid_r    <= 1'b0;
         first_r    <= 1'b0;
         last_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r    <= RUN;
                  tx_r       <= '0;
                  ty_r       <= '0;
                  c_r        <= '0;
                  r_r        <= '0;
                  addr_r     <= '0;
                  org_r      <= '0;
                  row_base_r <= '0;
                  valid_r    <= 1'b1;
                  first_r    <= 1'b1;
                  last_r     <= (WIN == 1);
                  busy_r     <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               done_r <= 1'b0;
               if (valid_r && addr_ready) begin
                  if (final_s) begin
                     state_r <= IDLE;
                     addr_r  <= '0;
                     valid_r <= 1'b0;
                     first_r <= 1'b0;
                     last_r  <= 1'b0;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     tx_r       <= tx_n_s;
                     ty_r       <= ty_n_s;
                     c_r        <= c_n_s;
                     r_r        <= r_n_s;
                     addr_r     <= addr_n_s;
                     org_r      <= org_n_s;
                     row_base_r <= row_base_n_s;
                     first_r    <= first_n_s;
                     last_r     <= last_n_s;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               state_r <= IDLE;
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign addr       = addr_r;
   assign addr_valid = valid_r;
   assign win_first  = first_r;
   assign win_last   = last_r;
   assign busy       = busy_r;
   assign frame_done = done_r;

endmodule

// File: tb/tb_window_addr_gen.sv
// Bench for window_addr_gen: three geometries, random backpressure, nested-loop reference model.
module tb_window_addr_gen;

   logic        clk;
   logic        rst_n;
   logic        start_a [3];
   logic        ready_a [3];
   logic [13:0] addr_a  [3];
   logic        valid_a [3];
   logic        first_a [3];
   logic        last_a  [3];
   logic        busy_a  [3];
   logic        done_a  [3];

   int errors = 0;
   int checks = 0;

   int gw [3] = '{50, 7, 8};
   int gh [3] = '{50, 7, 5};
   int gs [3] = '{1, 2, 2};

   typedef struct {
      int addr;
      int first;
      int last;
   } tap_t;

   window_addr_gen #(.IMG_W(50), .IMG_H(50), .WIN(3), .STRIDE(1), .ADDR_W(14)) u_d0 (
      .clk(clk), .rst_n(rst_n), .start(start_a[0]), .addr(addr_a[0]),
      .addr_valid(valid_a[0]), .addr_ready(ready_a[0]), .win_first(first_a[0]),
      .win_last(last_a[0]), .busy(busy_a[0]), .frame_done(done_a[0]));

   window_addr_gen #(.IMG_W(7), .IMG_H(7), .WIN(3), .STRIDE(2), .ADDR_W(14)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_a[1]), .addr(addr_a[1]),
      .addr_valid(valid_a[1]), .addr_ready(ready_a[1]), .win_first(first_a[1]),
      .win_last(last_a[1]), .busy(busy_a[1]), .frame_done(done_a[1]));

   window_addr_gen #(.IMG_W(8), .IMG_H(5), .WIN(3), .STRIDE(2), .ADDR_W(14)) u_d2 (
      .clk(clk), .rst_n(rst_n), .start(start_a[2]), .addr(addr_a[2]),
      .addr_valid(valid_a[2]), .addr_ready(ready_a[2]), .win_first(first_a[2]),
      .win_last(last_a[2]), .busy(busy_a[2]), .frame_done(done_a[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: ready=1; 1: random ready; 2: stall 5 cycles at addr 51 then random.
   // stop_at >= 0: assert reset when that address is presented and return.
   task automatic run_frame(input int k, input int mode, input bit hold_start,
                            input int stop_at, input int exp_total, input int exp_last);
      tap_t q[$];
      tap_t t;
      int   n = 0, last_acc = -1, hs_cyc = -100, stall_cnt = 0, prev_addr = 0;
      int   budget;
      bit   prev_stall = 1'b0, seen_done = 1'b0, rdy;
      for (int r = 0; r + 3 <= gh[k]; r += gs[k])
         for (int c = 0; c + 3 <= gw[k]; c += gs[k])
            for (int ty = 0; ty < 3; ty++)
               for (int tx = 0; tx < 3; tx++) begin
                  t.addr  = (r + ty) * gw[k] + c + tx;
                  t.first = (tx == 0 && ty == 0) ? 1 : 0;
                  t.last  = (tx == 2 && ty == 2) ? 1 : 0;
                  q.push_back(t);
               end
      budget = 8 * q.size() + 50;
      start_a[k] = 1'b1;
      @(negedge clk);
      if (!hold_start) start_a[k] = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (done_a[k]) begin
            check("done_latency", cyc - hs_cyc, 1);
            check("done_valid", int'(valid_a[k]), 0);
            check("done_busy", int'(busy_a[k]), 0);
            seen_done = 1'b1;
            break;
         end
         check("valid_in_run", int'(valid_a[k]), 1);
         check("busy_in_run", int'(busy_a[k]), 1);
         if (prev_stall) check("hold_addr", int'(addr_a[k]), prev_addr);
         if (stop_at >= 0 && valid_a[k] && int'(addr_a[k]) == stop_at) begin
            ready_a[k] = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            check("rst_addr", int'(addr_a[k]), 0);
            check("rst_valid", int'(valid_a[k]), 0);
            check("rst_flags", int'({first_a[k], last_a[k], busy_a[k], done_a[k]}), 0);
            repeat (3) begin
               @(negedge clk);
               check("rst_idle", int'({valid_a[k], busy_a[k]}), 0);
            end
            rst_n = 1'b1;
            return;
         end
         case (mode)
            0: rdy = 1'b1;
            2: if (int'(addr_a[k]) == 51 && stall_cnt < 5) begin
                  rdy = 1'b0;
                  stall_cnt++;
               end else begin
                  rdy = ($urandom % 4) != 0;
               end
            default: rdy = ($urandom % 4) != 0;
         endcase
         ready_a[k] = rdy;
         if (rdy && valid_a[k]) begin
            if (q.size() == 0) begin
               check("extra_tap", 1, 0);
            end else begin
               t = q.pop_front();
               check("addr", int'(addr_a[k]), t.addr);
               check("win_first", int'(first_a[k]), t.first);
               check("win_last", int'(last_a[k]), t.last);
            end
            n++;
            last_acc = int'(addr_a[k]);
            hs_cyc = cyc;
         end
         prev_stall = valid_a[k] && !rdy;
         prev_addr  = int'(addr_a[k]);
         @(negedge clk);
      end
      ready_a[k] = 1'b0;
      check("frame_done_seen", int'(seen_done), 1);
      check("tap_count", n, exp_total);
      check("last_addr", last_acc, exp_last);
      if (mode == 2) check("stall_cycles", stall_cnt, 5);
      @(negedge clk);
      if (hold_start) begin
         check("restart_valid", int'(valid_a[k]), 1);
         check("restart_addr", int'(addr_a[k]), 0);
         check("restart_first", int'(first_a[k]), 1);
         check("restart_done", int'(done_a[k]), 0);
         start_a[k] = 1'b0;
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check("post_reset_valid", int'(valid_a[k]), 0);
      end else begin
         check("done_pulse_width", int'(done_a[k]), 0);
         check("idle_valid", int'(valid_a[k]), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_a[i] = 1'b0;
         ready_a[i] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("reset_addr", int'(addr_a[0]), 0);
      check("reset_flags", int'({valid_a[0], first_a[0], last_a[0], busy_a[0], done_a[0]}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_start", int'(valid_a[0]), 0);

      run_frame(0, 0, 1'b0, -1, 20736, 2499);
      run_frame(0, 2, 1'b0, -1, 20736, 2499);
      run_frame(1, 1, 1'b0, -1, 81, 48);
      run_frame(2, 1, 1'b0, -1, 54, 38);
      run_frame(0, 1, 1'b0, 500, 0, 0);
      run_frame(0, 0, 1'b0, 500, 0, 0);
      run_frame(1, 0, 1'b1, -1, 81, 48);
      run_frame(2, 0, 1'b0, -1, 54, 38);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
